// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_unit
// Purpose  : Iterative signed multiply (radix-2 Booth) / restoring divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH    = 32,
  parameter int IR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ctrl_MULT,
  input  logic                ctrl_DIV,
  input  logic [WIDTH-1:0]    data_operandA,
  input  logic [WIDTH-1:0]    data_operandB,
  input  logic [IR_WIDTH-1:0] in_IR,
  output logic [WIDTH-1:0]    data_result,
  output logic                data_exception,
  output logic                data_resultRDY,
  output logic                busy,
  output logic [IR_WIDTH-1:0] out_IR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    c_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_NEG1 = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_op_div;
  logic [WIDTH:0]  r_hi;
  logic [WIDTH-1:0] r_lo;
  logic            r_qm1;
  logic [WIDTH-1:0] r_m;
  logic            r_neg;
  logic            r_div0;
  logic            r_ovf;

  logic             w_start;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_qm1_nxt;
  logic [WIDTH:0]   w_prod_top;
  logic             w_mul_ovf;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_res_fin;
  logic             w_exc_fin;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  // One iteration of either datapath; r_hi carries a guard bit so Booth
  // add/subtract of the most-negative multiplicand cannot overflow.
  always_comb begin
    w_m_ext  = {r_m[WIDTH-1], r_m};
    w_sum    = r_hi;
    w_rem_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_m};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    w_qm1_nxt = 1'b0;
    if (!r_op_div) begin
      case ({r_lo[0], r_qm1})
        2'b01:   w_sum = r_hi + w_m_ext;
        2'b10:   w_sum = r_hi - w_m_ext;
        default: w_sum = r_hi;
      endcase
      w_hi_nxt  = {w_sum[WIDTH], w_sum[WIDTH:1]};
      w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
      w_qm1_nxt = r_lo[0];
    end else if (!w_diff[WIDTH]) begin
      w_hi_nxt = w_diff;
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_rem_sh;
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign w_prod_top = {w_hi_nxt[WIDTH-1:0], w_lo_nxt[WIDTH-1]};
  assign w_mul_ovf  = ~((&w_prod_top) | ~(|w_prod_top));
  assign w_quot     = r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
  assign w_res_fin  = r_op_div ? (r_div0 ? {WIDTH{1'b0}} : w_quot) : w_lo_nxt;
  assign w_exc_fin  = r_op_div ? (r_div0 | r_ovf) : w_mul_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op_div       <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_qm1          <= 1'b0;
      r_m            <= '0;
      r_neg          <= 1'b0;
      r_div0         <= 1'b0;
      r_ovf          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
      out_IR         <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          data_resultRDY <= 1'b0;
          if (w_start) begin
            r_state  <= S_RUN;
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_op_div <= ~ctrl_MULT;
            r_hi     <= '0;
            r_qm1    <= 1'b0;
            out_IR   <= in_IR;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_div0   <= (data_operandB == '0);
            r_ovf    <= (data_operandA == c_MIN) && (data_operandB == c_NEG1);
            if (ctrl_MULT) begin
              r_lo <= data_operandB;
              r_m  <= data_operandA;
            end else begin
              r_lo <= w_abs_a;
              r_m  <= w_abs_b;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state        <= S_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= w_res_fin;
            data_exception <= w_exc_fin;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_unit
// Purpose  : Randomised and directed checks of multdiv_unit against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ctrl_MULT, ctrl_DIV;
  logic [W-1:0]  data_operandA, data_operandB;
  logic [W-1:0]  in_IR;
  logic [W-1:0]  data_result;
  logic          data_exception, data_resultRDY, busy;
  logic [W-1:0]  out_IR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multdiv_unit #(.WIDTH(W), .IR_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .in_IR(in_IR),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy), .out_IR(out_IR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact 64-bit signed product / truncating signed division.
  task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endtask

  task automatic do_start(input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ir);
    ctrl_MULT = m; ctrl_DIV = d;
    data_operandA = a; data_operandB = b; in_IR = ir;
    @(posedge clk);
    t_start = cyc + 1;
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom; in_IR = $urandom;
    check("ir_at_start", out_IR, ir);
    check("busy_at_start", busy, 1'b1);
  endtask

  task automatic wait_rdy(output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (data_resultRDY === 1'b1) begin
        lat = cyc - t_start;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rdy_timeout", 0, 1);
  endtask

  task automatic op(input string tag, input bit m, input bit d, input logic [31:0] a,
                    input logic [31:0] b, input bit b2b);
    logic [31:0] er, ir;
    logic        ee;
    int          lat;
    bit          ok;
    ir = $urandom;
    model(m, a, b, er, ee);
    do_start(m, d, a, b, ir);
    wait_rdy(lat, ok);
    if (ok) begin
      check({tag, ".latency"}, lat, 32);
      check({tag, ".result"}, data_result, er);
      check({tag, ".exc"}, data_exception, ee);
      check({tag, ".out_ir"}, out_IR, ir);
      check({tag, ".busy_done"}, busy, 1'b0);
      if (!b2b) begin
        @(negedge clk);
        check({tag, ".rdy_pulse"}, data_resultRDY, 1'b0);
        check({tag, ".hold"}, data_result, er);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, er, ir;
    logic        ee;
    int          lat, sel;
    bit          ok, m, d, seen;
    logic [31:0] specials [5];
    specials = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1};

    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0; in_IR = '0;
    repeat (3) @(negedge clk);
    check("reset.result", data_result, 0);
    check("reset.exc", data_exception, 0);
    check("reset.rdy", data_resultRDY, 0);
    check("reset.busy", busy, 0);
    check("reset.out_ir", out_IR, 0);
    reset = 1'b1;
    @(negedge clk);

    op("mul_7x-6", 1, 0, 32'd7, -32'sd6, 0);
    check("mul_7x-6.value", data_result, 32'hFFFF_FFD6);
    op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 0);
    check("mul_ovf.exc_const", data_exception, 1);
    op("mul_min", 1, 0, 32'h8000_0000, 32'd1, 0);
    op("div_-100/7", 0, 1, -32'sd100, 32'd7, 0);
    check("div_-100/7.value", data_result, 32'hFFFF_FFF2);
    op("div_100/-7", 0, 1, 32'd100, -32'sd7, 0);
    op("div_by0", 0, 1, 32'd5, 32'd0, 0);
    op("div_minneg", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_minneg.value", data_result, 32'h8000_0000);
    op("both_ctrl", 1, 1, 32'd9, 32'd11, 0);
    check("both_ctrl.value", data_result, 32'd99);

    // A DIV request mid-multiply must be dropped.
    ir = 32'hCAFE_0001;
    model(1, 32'd1234, -32'sd77, er, ee);
    do_start(1, 0, 32'd1234, -32'sd77, ir);
    repeat (10) @(negedge clk);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    @(negedge clk);
    ctrl_DIV = 1'b0;
    wait_rdy(lat, ok);
    if (ok) begin
      check("ignore.latency", lat, 32);
      check("ignore.result", data_result, er);
      check("ignore.exc", data_exception, ee);
    end
    @(negedge clk);
    check("ignore.no_second_rdy", data_resultRDY, 0);
    repeat (40) @(negedge clk);
    check("ignore.idle_busy", busy, 0);

    // Back-to-back: second start issued in the DONE cycle.
    op("b2b_first", 0, 1, 32'd1000, 32'd3, 1);
    op("b2b_second", 1, 0, -32'sd5, 32'd5, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      m   = $urandom_range(0, 1);
      d   = !m;
      if ($urandom_range(0, 7) == 0) begin
        m = 1; d = 1;
      end
      case (sel)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 2000) - 1000; end
        2: begin a = $urandom; b = d && !m ? 32'd0 : $urandom_range(0, 65535); end
        default: begin a = specials[$urandom_range(0, 4)]; b = specials[$urandom_range(0, 4)]; end
      endcase
      op($sformatf("rand%0d", i), m, d, a, b, $urandom_range(0, 1) == 1);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    do_start(0, 1, 32'd100, 32'd7, 32'h1234_5678);
    repeat (12) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset.result", data_result, 0);
    check("midreset.exc", data_exception, 0);
    check("midreset.rdy", data_resultRDY, 0);
    check("midreset.busy", busy, 0);
    check("midreset.out_ir", out_IR, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (data_resultRDY === 1'b1) seen = 1'b1;
    end
    check("midreset.no_rdy", seen, 0);
    op("post_reset_3x4", 1, 0, 32'd3, 32'd4, 0);
    check("post_reset_3x4.value", data_result, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
